// File: rtl/ex_mem_pkg.sv
// Shared control types and field positions for the EX->MEM pipeline stage.
package ex_mem_pkg;

    // Bit positions inside the 3-bit {branch, mem_read, mem_write} control bus.
    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;

    // Width of the write-back control field carried in ex_mem_ctrl_t.
    localparam int CTRL_WB_W  = 2;

    typedef struct packed {
        logic                 branch;
        logic                 mem_read;
        logic                 mem_write;
        logic [CTRL_WB_W-1:0] wb;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/ex_mem_if.sv
// EX->MEM handshake bundle: upstream valid/ready with entry fields, downstream head view.
interface ex_mem_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BR_ADDR_W  = 7,
    parameter int WB_W       = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_alu;
    logic [DATA_W-1:0]     in_write_data;
    logic [BR_ADDR_W-1:0]  in_br_addr;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [WB_W-1:0]       in_wb;
    logic [2:0]            in_mem;
    logic                  in_zf;
    logic                  in_bne;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_alu;
    logic [DATA_W-1:0]     out_write_data;
    logic [BR_ADDR_W-1:0]  out_br_addr;
    logic [REG_ADDR_W-1:0] out_rd;
    logic [WB_W-1:0]       out_wb;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic                  out_branch_taken;

    modport master (
        output in_valid, in_alu, in_write_data, in_br_addr, in_rd, in_wb, in_mem,
               in_zf, in_bne, out_ready,
        input  in_ready, out_valid, out_alu, out_write_data, out_br_addr, out_rd,
               out_wb, out_mem_read, out_mem_write, out_branch_taken
    );

    modport slave (
        input  in_valid, in_alu, in_write_data, in_br_addr, in_rd, in_wb, in_mem,
               in_zf, in_bne, out_ready,
        output in_ready, out_valid, out_alu, out_write_data, out_br_addr, out_rd,
               out_wb, out_mem_read, out_mem_write, out_branch_taken
    );
endinterface

// File: rtl/ex_mem_skid.sv
// One pipeline entry: payload register plus valid bit; payload only moves on load_i.
module ex_mem_skid #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         vld_d_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);
    logic         vld_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q <= vld_d_i;
            if (load_i) data_q <= d_i;
        end
    end

    assign vld_o = vld_q;
    assign q_o   = data_q;
endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: 2-entry skid buffer (head + skid), registered in_ready, sync flush.
// Optional EX_MEM_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BR_ADDR_W  = 7,
    parameter int WB_W       = CTRL_WB_W
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    ex_mem_if.slave     bus
`ifdef EX_MEM_PERF_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);
    typedef struct packed {
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     wdata;
        logic [BR_ADDR_W-1:0]  br_addr;
        logic [REG_ADDR_W-1:0] rd;
        ex_mem_ctrl_t          ctrl;
        logic                  taken;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t in_e, head_e, skid_e, head_d;
    logic   head_v, skid_v, head_vd, skid_vd;
    logic   head_ld, skid_ld, head_from_skid;
    logic   acc, pass;

    // Branch outcome is resolved once at capture so the head never re-evaluates flags.
    always_comb begin
        in_e            = '0;
        in_e.alu        = bus.in_alu;
        in_e.wdata      = bus.in_write_data;
        in_e.br_addr    = bus.in_br_addr;
        in_e.rd         = bus.in_rd;
        in_e.ctrl.branch    = bus.in_mem[MEM_BRANCH];
        in_e.ctrl.mem_read  = bus.in_mem[MEM_READ];
        in_e.ctrl.mem_write = bus.in_mem[MEM_WRITE];
        in_e.ctrl.wb        = bus.in_wb;
        in_e.taken      = bus.in_mem[MEM_BRANCH] & (bus.in_zf ^ bus.in_bne);
    end

    // in_ready is the inverted skid valid flop, so upstream sees no combinational path.
    assign acc  = bus.in_valid & ~skid_v;
    assign pass = head_v & bus.out_ready;

    always_comb begin
        head_ld        = 1'b0;
        skid_ld        = 1'b0;
        head_from_skid = 1'b0;
        head_vd        = head_v;
        skid_vd        = skid_v;
        if (flush) begin
            head_vd = 1'b0;
            skid_vd = 1'b0;
        end else if (skid_v) begin
            if (pass) begin
                head_ld        = 1'b1;
                head_from_skid = 1'b1;
                skid_vd        = 1'b0;
            end
        end else if (acc && (!head_v || pass)) begin
            head_ld = 1'b1;
            head_vd = 1'b1;
        end else if (acc) begin
            skid_ld = 1'b1;
            skid_vd = 1'b1;
        end else if (pass) begin
            head_vd = 1'b0;
        end
    end

    assign head_d = head_from_skid ? skid_e : in_e;

    ex_mem_skid #(.W(EW)) u_head (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (head_ld),
        .vld_d_i (head_vd),
        .d_i     (head_d),
        .vld_o   (head_v),
        .q_o     (head_e)
    );

    ex_mem_skid #(.W(EW)) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (skid_ld),
        .vld_d_i (skid_vd),
        .d_i     (in_e),
        .vld_o   (skid_v),
        .q_o     (skid_e)
    );

    assign bus.in_ready         = ~skid_v;
    assign bus.out_valid        = head_v;
    assign bus.out_alu          = head_e.alu;
    assign bus.out_write_data   = head_e.wdata;
    assign bus.out_br_addr      = head_e.br_addr;
    assign bus.out_rd           = head_e.rd;
    assign bus.out_wb           = head_e.ctrl.wb;
    assign bus.out_mem_read     = head_v & head_e.ctrl.mem_read;
    assign bus.out_mem_write    = head_v & head_e.ctrl.mem_write;
    assign bus.out_branch_taken = head_v & head_e.ctrl.branch & head_e.taken;

`ifdef EX_MEM_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (head_v && !bus.out_ready && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule
